firebird7_in_gate1_tessent_tdr_data_override: RTL

IJTAG test data register that sits directly upstream of the gate1 19-bit data mux and drives its `ijtag_select` and `ijtag_data_in` inputs. It captures the functional data word for observation and shifts in a new override word. The override is applied only after a complete, correctly sized shift. Partial or over-length scans never corrupt the override path.

---
 rtl/firebird7_in_gate1_tdr_pkg.sv | 35 +++
 rtl/firebird7_in_gate1_tdr_shift_cnt.sv | 44 ++++
 rtl/firebird7_in_gate1_tessent_tdr_data_override.sv | 105 ++++++++++
 3 files changed

// File: rtl/firebird7_in_gate1_tdr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : firebird7_in_gate1_tdr_pkg
//  Description : Shared definitions for the gate1 data-override IJTAG TDR.
//                Bit positions of the select and status fields inside the
//                scan register, and the shift-length counter type.
//  Revision    : 1.0  initial release
// ============================================================================
package firebird7_in_gate1_tdr_pkg;

    localparam int DEFAULT_DATA_WIDTH = 19;

    // Select bit is the top of the scan register (nearest SI).
    function automatic int sel_pos(input int data_width);
        return data_width + 1;
    endfunction

    // Status bit sits directly above the data field.
    function automatic int stat_pos(input int data_width);
        return data_width;
    endfunction

    // Counter must hold 0 .. LEN+1, with LEN = data_width + 2.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 4);
    endfunction

    localparam int SEL_POS  = sel_pos(DEFAULT_DATA_WIDTH);
    localparam int STAT_POS = stat_pos(DEFAULT_DATA_WIDTH);
    localparam int CNT_W    = cnt_width(DEFAULT_DATA_WIDTH);

    typedef logic [CNT_W-1:0] cnt_t;

endpackage
`default_nettype wire

// File: rtl/firebird7_in_gate1_tdr_shift_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : firebird7_in_gate1_tdr_shift_cnt
//  Description : Saturating shift-length counter. Cleared on capture,
//                incremented on every shift, saturates at LEN+1 so that an
//                over-length scan is remembered as overrun. o_complete is
//                high only when exactly LEN bits were shifted.
//  Ports       : clk        - scan clock (rising edge)
//                rst_n      - asynchronous active-low reset
//                i_clear    - capture cycle, return count to zero
//                i_shift    - shift cycle, advance count
//                o_complete - count equals LEN
//  Revision    : 1.0  initial release
// ============================================================================
module firebird7_in_gate1_tdr_shift_cnt #(
    parameter int LEN   = 21,
    parameter int CNT_W = $clog2(LEN + 2)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_shift,
    output logic o_complete
);

    localparam logic [CNT_W-1:0] C_LEN = CNT_W'(LEN);
    localparam logic [CNT_W-1:0] C_OVF = CNT_W'(LEN + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_shift && (r_cnt != C_OVF)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_complete = (r_cnt == C_LEN);

endmodule
`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_tdr_data_override.sv
`default_nettype none
// ============================================================================
//  Module      : firebird7_in_gate1_tessent_tdr_data_override
//  Description : IJTAG TDR feeding the gate1 data mux override inputs.
//                Captures the functional word for observation, shifts in a
//                new {select, status, data} word and applies it on update
//                only if exactly LEN bits were shifted since the last
//                capture. Rejected updates set a sticky error flag.
//  Ports       : ijtag_tck          - scan clock (shift/capture rising,
//                                     update falling)
//                ijtag_reset        - asynchronous active-low reset
//                ijtag_sel/ce/se/ue - select, capture/shift/update enables
//                ijtag_si/ijtag_so  - scan in / scan out
//                functional_data_in - observed functional word
//                ijtag_select       - mux select (1 = override)
//                ijtag_data_in      - override word
//                update_error       - sticky rejected-update flag
//  Revision    : 1.0  initial release
// ============================================================================
module firebird7_in_gate1_tessent_tdr_data_override
    import firebird7_in_gate1_tdr_pkg::*;
#(
    parameter int DATA_WIDTH = 19
) (
    input  logic                  ijtag_tck,
    input  logic                  ijtag_reset,
    input  logic                  ijtag_sel,
    input  logic                  ijtag_ce,
    input  logic                  ijtag_se,
    input  logic                  ijtag_ue,
    input  logic                  ijtag_si,
    output logic                  ijtag_so,
    input  logic [DATA_WIDTH-1:0] functional_data_in,
    output logic                  ijtag_select,
    output logic [DATA_WIDTH-1:0] ijtag_data_in,
    output logic                  update_error
);

    localparam int LEN        = DATA_WIDTH + 2;
    localparam int C_SEL_POS  = sel_pos(DATA_WIDTH);
    localparam int CNT_WIDTH  = cnt_width(DATA_WIDTH);

    logic [LEN-1:0]        r_sr;
    logic                  r_select;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_update_error;

    logic w_capture;
    logic w_shift;
    logic w_update;
    logic w_complete;

    // Capture wins over shift when both enables are high.
    assign w_capture = ijtag_sel & ijtag_ce;
    assign w_shift   = ijtag_sel & ijtag_se & ~ijtag_ce;
    assign w_update  = ijtag_sel & ijtag_ue;

    firebird7_in_gate1_tdr_shift_cnt #(
        .LEN   (LEN),
        .CNT_W (CNT_WIDTH)
    ) u_shift_cnt (
        .clk        (ijtag_tck),
        .rst_n      (ijtag_reset),
        .i_clear    (w_capture),
        .i_shift    (w_shift),
        .o_complete (w_complete)
    );

    // Scan register: the status field captures the sticky error so that
    // software can see whether the previous update was accepted.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            r_sr <= '0;
        end else if (w_capture) begin
            r_sr <= {r_select, r_update_error, functional_data_in};
        end else if (w_shift) begin
            r_sr <= {ijtag_si, r_sr[LEN-1:1]};
        end
    end

    // Update registers on the falling edge. The shifted-in status bit is
    // deliberately ignored; only select and data are applied.
    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            r_select       <= 1'b0;
            r_data         <= '0;
            r_update_error <= 1'b0;
        end else if (w_update) begin
            if (w_complete) begin
                r_select       <= r_sr[C_SEL_POS];
                r_data         <= r_sr[DATA_WIDTH-1:0];
                r_update_error <= 1'b0;
            end else begin
                r_update_error <= 1'b1;
            end
        end
    end

    assign ijtag_so      = r_sr[0];
    assign ijtag_select  = r_select;
    assign ijtag_data_in = r_data;
    assign update_error  = r_update_error;

endmodule
`default_nettype wire
